// File: rtl/bat_output_uart.sv
// Output-port UART: buffers 16-bit CPU output words in a small FIFO and sends
// each one as two 8N1 frames, low byte first.
//
// state   | meaning
// S_IDLE  | line high; pops the head word into the holding register when present
// S_START | start bit (low) for one bit time
// S_DATA  | eight data bits of the selected byte, LSB first
// S_STOP  | stop bit (high); chains to the high byte or returns to idle
module bat_output_uart #(
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] OUT_DATA,
  input  logic                  OUT_WR,
  output logic                  TX,
  output logic                  BUSY,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  OVERFLOW
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_TC = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow_q;

  state_t                state, state_n;
  logic [BW-1:0]         baud_cnt, baud_n;
  logic [2:0]            bit_idx, idx_n;
  logic                  byte_sel, sel_n;
  logic [DATA_WIDTH-1:0] holding;
  logic                  tx_q, tx_bit;
  logic [7:0]            cur_byte;

  logic pop, push;

  assign pop  = (state == S_IDLE) && (count != '0);
  assign push = OUT_WR && ((count != DEPTH_C) || pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= OUT_DATA;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (OUT_WR && !push) overflow_q <= 1'b1;
    end
  end

  assign cur_byte = byte_sel ? holding[DATA_WIDTH-1 -: 8] : holding[7:0];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      holding  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= idx_n;
      byte_sel <= sel_n;
      if (pop) holding <= mem[rd_ptr];
      // TX follows the current state one cycle late, so the line lags the FSM
      tx_q     <= tx_bit;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    idx_n   = bit_idx;
    sel_n   = byte_sel;
    tx_bit  = 1'b1;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          sel_n   = 1'b0;
          baud_n  = BAUD_TC;
          state_n = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (baud_cnt == '0) begin
          baud_n  = BAUD_TC;
          idx_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      S_DATA: begin
        tx_bit = cur_byte[bit_idx];
        if (baud_cnt == '0) begin
          baud_n = BAUD_TC;
          if (bit_idx == 3'd7) state_n = S_STOP;
          else                 idx_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_cnt == '0) begin
          if (!byte_sel) begin
            sel_n   = 1'b1;
            baud_n  = BAUD_TC;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign TX       = tx_q;
  assign BUSY     = (state != S_IDLE);
  assign FULL     = (count == DEPTH_C);
  assign EMPTY    = (count == '0);
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_bat_output_uart.sv
// Directed bench for bat_output_uart: a line decoder records every 8N1 frame
// and each scenario task compares the decoded bytes and status flags.
module tb_bat_output_uart;

  localparam int CPB = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] OUT_DATA = '0;
  logic        OUT_WR = 1'b0;
  logic        TX, BUSY, FULL, EMPTY, OVERFLOW;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         frame_err = 0;

  bat_output_uart #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RESET(RESET), .OUT_DATA(OUT_DATA), .OUT_WR(OUT_WR),
    .TX(TX), .BUSY(BUSY), .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Line decoder: every bit must hold one value for exactly CPB cycles
  int         m_t0;
  logic       m_bad, m_abort, m_v;
  logic [7:0] m_sh;
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1 && TX === 1'b0) begin
        m_t0 = cyc; m_bad = 1'b0; m_abort = 1'b0; m_sh = '0; m_v = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (!(b == 0 && k == 0)) @(negedge CLK);
            if (RESET !== 1'b1) m_abort = 1'b1;
            if (k == 0) m_v = TX;
            else if (TX !== m_v) m_bad = 1'b1;
          end
          if (b == 0 && m_v !== 1'b0) m_bad = 1'b1;
          if (b == 9 && m_v !== 1'b1) m_bad = 1'b1;
          if (b >= 1 && b <= 8) m_sh[b-1] = m_v;
        end
        if (!m_abort) begin
          rx_q.push_back(m_sh);
          rx_t.push_back(m_t0);
          if (m_bad) frame_err = frame_err + 1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK); RESET = 1'b0; OUT_WR = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic write_burst(input logic [15:0] first, input int n,
                             input logic [15:0] step, output int wr_edge);
    logic [15:0] d;
    d = first;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i == 0) wr_edge = cyc + 1;
      OUT_WR = 1'b1; OUT_DATA = d;
      d = d + step;
    end
    @(negedge CLK);
    OUT_WR = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge CLK);
    checks++;
    if (rx_q.size() < n) begin
      fails++;
      $display("FAIL %s timeout: bytes seen %0d, required %0d", tag, rx_q.size(), n);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && !(BUSY === 1'b0 && EMPTY === 1'b1); i++) @(negedge CLK);
    checks++;
    if (!(BUSY === 1'b0 && EMPTY === 1'b1)) begin
      fails++;
      $display("FAIL idle_timeout: BUSY=%b EMPTY=%b, required 0/1", BUSY, EMPTY);
    end
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({TX, BUSY, FULL, EMPTY, OVERFLOW} !== 5'b10010) begin
      fails++;
      $display("FAIL reset_values: TX,BUSY,FULL,EMPTY,OVF=%b required 10010",
               {TX, BUSY, FULL, EMPTY, OVERFLOW});
    end
    RESET = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      checks++;
      if ({TX, BUSY, EMPTY, OVERFLOW} !== 4'b1010) begin
        fails++;
        $display("FAIL idle_cycle%0d: TX,BUSY,EMPTY,OVF=%b required 1010", i,
                 {TX, BUSY, EMPTY, OVERFLOW});
      end
    end
  endtask

  task automatic test_single();
    int base, fe0, we, bc;
    base = rx_q.size(); fe0 = frame_err; bc = 0;
    write_burst(16'hA55A, 1, 16'h0, we);
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b1) bc++;
      else if (bc > 0) break;
    end
    checks++;
    if (bc !== 80) begin
      fails++; $display("FAIL single_busy_len: got %0d cycles, required 80", bc);
    end
    checks++;
    if (EMPTY !== 1'b1) begin
      fails++; $display("FAIL single_empty_after: got %b, required 1", EMPTY);
    end
    wait_bytes(base + 2, 50, "single");
    if (rx_q.size() >= base + 2) begin
      checks++;
      if (rx_q[base] !== 8'h5A) begin
        fails++; $display("FAIL single_byte0: got %h, required 5a", rx_q[base]);
      end
      checks++;
      if (rx_q[base+1] !== 8'hA5) begin
        fails++; $display("FAIL single_byte1: got %h, required a5", rx_q[base+1]);
      end
      checks++;
      if (rx_t[base] - we !== 2) begin
        fails++; $display("FAIL single_latency: got %0d, required 2", rx_t[base] - we);
      end
      checks++;
      if (rx_t[base+1] - rx_t[base] !== 10*CPB) begin
        fails++; $display("FAIL single_byte_spacing: got %0d, required %0d",
                          rx_t[base+1] - rx_t[base], 10*CPB);
      end
    end
    checks++;
    if (frame_err !== fe0) begin
      fails++; $display("FAIL single_framing: errors %0d, required %0d", frame_err, fe0);
    end
    wait_idle();
  endtask

  task automatic test_five();
    int base, fe0, we;
    logic [7:0] exp;
    base = rx_q.size(); fe0 = frame_err;
    write_burst(16'h0001, 5, 16'h0001, we);
    checks++;
    if (OVERFLOW !== 1'b0) begin
      fails++; $display("FAIL five_overflow: got %b, required 0", OVERFLOW);
    end
    checks++;
    if (FULL !== 1'b1) begin
      fails++; $display("FAIL five_full: got %b, required 1", FULL);
    end
    wait_bytes(base + 10, 600, "five");
    for (int i = 0; i < 10 && base + i < rx_q.size(); i++) begin
      exp = (i % 2 == 0) ? 8'(i/2 + 1) : 8'h00;
      checks++;
      if (rx_q[base+i] !== exp) begin
        fails++; $display("FAIL five_byte%0d: got %h, required %h", i, rx_q[base+i], exp);
      end
    end
    if (rx_q.size() >= base + 3) begin
      checks++;
      if (rx_t[base+2] - rx_t[base] !== 20*CPB + 1) begin
        fails++; $display("FAIL five_word_gap: got %0d, required %0d",
                          rx_t[base+2] - rx_t[base], 20*CPB + 1);
      end
    end
    checks++;
    if (frame_err !== fe0 || OVERFLOW !== 1'b0) begin
      fails++; $display("FAIL five_end: framing %0d ovf %b, required %0d/0", frame_err, OVERFLOW, fe0);
    end
    wait_idle();
  endtask

  task automatic test_overflow();
    int base, we;
    logic [7:0] exp;
    base = rx_q.size();
    write_burst(16'h0001, 6, 16'h0001, we);
    checks++;
    if ({FULL, OVERFLOW} !== 2'b11) begin
      fails++; $display("FAIL ovf_set: FULL,OVF=%b, required 11", {FULL, OVERFLOW});
    end
    wait_bytes(base + 10, 600, "ovf");
    repeat (150) @(negedge CLK);
    checks++;
    if (rx_q.size() !== base + 10) begin
      fails++; $display("FAIL ovf_byte_count: got %0d, required %0d", rx_q.size() - base, 10);
    end
    for (int i = 0; i < 10 && base + i < rx_q.size(); i++) begin
      exp = (i % 2 == 0) ? 8'(i/2 + 1) : 8'h00;
      checks++;
      if (rx_q[base+i] !== exp) begin
        fails++; $display("FAIL ovf_byte%0d: got %h, required %h", i, rx_q[base+i], exp);
      end
    end
    checks++;
    if (OVERFLOW !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky: got %b, required 1", OVERFLOW);
    end
    do_reset();
    checks++;
    if (OVERFLOW !== 1'b0) begin
      fails++; $display("FAIL ovf_cleared: got %b, required 0", OVERFLOW);
    end
  endtask

  task automatic test_full_pop();
    int base, we, n;
    logic [7:0] exp;
    base = rx_q.size();
    write_burst(16'h0001, 5, 16'h0001, we);
    n = 0;
    while (BUSY !== 1'b0 && n < 300) begin @(negedge CLK); n++; end
    checks++;
    if ({BUSY, FULL} !== 2'b01) begin
      fails++; $display("FAIL fullpop_pre: BUSY,FULL=%b, required 01", {BUSY, FULL});
    end
    OUT_WR = 1'b1; OUT_DATA = 16'h0006;
    @(negedge CLK);
    OUT_WR = 1'b0;
    checks++;
    if ({FULL, OVERFLOW, BUSY} !== 3'b101) begin
      fails++; $display("FAIL fullpop_post: FULL,OVF,BUSY=%b, required 101", {FULL, OVERFLOW, BUSY});
    end
    wait_bytes(base + 12, 800, "fullpop");
    for (int i = 0; i < 12 && base + i < rx_q.size(); i++) begin
      exp = (i % 2 == 0) ? 8'(i/2 + 1) : 8'h00;
      checks++;
      if (rx_q[base+i] !== exp) begin
        fails++; $display("FAIL fullpop_byte%0d: got %h, required %h", i, rx_q[base+i], exp);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int base, we, bad;
    base = rx_q.size(); bad = 0;
    write_burst(16'h1234, 2, 16'h4444, we);
    repeat (10) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1 || EMPTY !== 1'b0) begin
      fails++; $display("FAIL rmid_pre: BUSY,EMPTY=%b, required 10", {BUSY, EMPTY});
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({TX, EMPTY, BUSY} !== 3'b110) begin
      fails++; $display("FAIL rmid_async: TX,EMPTY,BUSY=%b, required 110", {TX, EMPTY, BUSY});
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      if (TX !== 1'b1 || BUSY !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++; $display("FAIL rmid_line_quiet: %0d active cycles, required 0", bad);
    end
    checks++;
    if (rx_q.size() !== base) begin
      fails++; $display("FAIL rmid_no_bytes: got %0d bytes, required 0", rx_q.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_five();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

endmodule
